// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I MEM/WB pipeline register with load wait, load alignment and register-file write port
// Optional read-first bypass outputs are enabled with `define WB_BYPASS_EN.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_mem,
  input  logic        RegWrite_mem,
  input  logic        MemtoReg_mem,
  input  logic        MemRead_mem,
  input  logic [4:0]  rdAddr_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] MemData_rdata,
  input  logic        MemData_rvalid,
`ifdef WB_BYPASS_EN
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic [31:0] rs1Data_rf,
  input  logic [31:0] rs2Data_rf,
  output logic [31:0] rs1Data_byp,
  output logic [31:0] rs2Data_byp,
`endif
  output logic        WBStall,
  output logic        RegWrite_wb,
  output logic [4:0]  rdAddr_wb,
  output logic [31:0] RegWriteData_wb
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state, state_n;
  logic        we_n;
  logic [4:0]  rd_n;
  logic [31:0] data_n;
  logic        pend_load;
  logic        pend_we;
  logic [4:0]  pend_rd;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_a;
  logic        is_load;

  function automatic logic [31:0] align_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b100:  align_load = {24'd0, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b101:  align_load = {16'd0, h};
      default: align_load = w;
    endcase
  endfunction

  // A MemtoReg instruction also waits for memory data, so either flag makes it a load.
  assign is_load = MemRead_mem | MemtoReg_mem;

  always_comb begin
    state_n   = state;
    we_n      = 1'b0;
    rd_n      = rdAddr_wb;
    data_n    = RegWriteData_wb;
    pend_load = 1'b0;
    case (state)
      IDLE: begin
        if (valid_mem) begin
          if (!is_load) begin
            we_n   = RegWrite_mem && (rdAddr_mem != 5'd0);
            rd_n   = rdAddr_mem;
            data_n = ALUResult_mem;
          end else if (MemData_rvalid) begin
            we_n   = RegWrite_mem && (rdAddr_mem != 5'd0);
            rd_n   = rdAddr_mem;
            data_n = align_load(MemData_rdata, funct3_mem, ALUResult_mem[1:0]);
          end else begin
            pend_load = 1'b1;
            state_n   = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (MemData_rvalid) begin
          we_n    = pend_we && (pend_rd != 5'd0);
          rd_n    = pend_rd;
          data_n  = align_load(MemData_rdata, pend_f3, pend_a);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      RegWrite_wb     <= 1'b0;
      rdAddr_wb       <= 5'd0;
      RegWriteData_wb <= 32'd0;
      pend_we         <= 1'b0;
      pend_rd         <= 5'd0;
      pend_f3         <= 3'd0;
      pend_a          <= 2'd0;
    end else begin
      state           <= state_n;
      RegWrite_wb     <= we_n;
      rdAddr_wb       <= rd_n;
      RegWriteData_wb <= data_n;
      if (pend_load) begin
        pend_we <= RegWrite_mem;
        pend_rd <= rdAddr_mem;
        pend_f3 <= funct3_mem;
        pend_a  <= ALUResult_mem[1:0];
      end
    end
  end

  assign WBStall = (state == WAIT_LOAD);

`ifdef WB_BYPASS_EN
  assign rs1Data_byp = (RegWrite_wb && (rdAddr_wb == rs1Addr_id)) ? RegWriteData_wb : rs1Data_rf;
  assign rs2Data_byp = (RegWrite_wb && (rdAddr_wb == rs2Addr_id)) ? RegWriteData_wb : rs2Data_rf;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed vector bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_mem, RegWrite_mem, MemtoReg_mem, MemRead_mem;
  logic [4:0]  rdAddr_mem;
  logic [31:0] ALUResult_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] MemData_rdata;
  logic        MemData_rvalid;
  logic        WBStall, RegWrite_wb;
  logic [4:0]  rdAddr_wb;
  logic [31:0] RegWriteData_wb;
`ifdef WB_BYPASS_EN
  logic [4:0]  rs1Addr_id, rs2Addr_id;
  logic [31:0] rs1Data_rf, rs2Data_rf, rs1Data_byp, rs2Data_byp;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset),
    .valid_mem(valid_mem), .RegWrite_mem(RegWrite_mem), .MemtoReg_mem(MemtoReg_mem),
    .MemRead_mem(MemRead_mem), .rdAddr_mem(rdAddr_mem), .ALUResult_mem(ALUResult_mem),
    .funct3_mem(funct3_mem), .MemData_rdata(MemData_rdata), .MemData_rvalid(MemData_rvalid),
`ifdef WB_BYPASS_EN
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rs1Data_rf(rs1Data_rf),
    .rs2Data_rf(rs2Data_rf), .rs1Data_byp(rs1Data_byp), .rs2Data_byp(rs2Data_byp),
`endif
    .WBStall(WBStall), .RegWrite_wb(RegWrite_wb), .rdAddr_wb(rdAddr_wb),
    .RegWriteData_wb(RegWriteData_wb)
  );

  typedef struct {
    string       name;
    logic        valid, rw, m2r, mrd;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        rvalid;
    logic        exp_we;
    logic        chk_data;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic mrd,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [2:0] f3,
                       input logic [31:0] rdata, input logic rvalid);
    valid_mem = v; RegWrite_mem = rw; MemtoReg_mem = m2r; MemRead_mem = mrd;
    rdAddr_mem = rd; ALUResult_mem = alu; funct3_mem = f3;
    MemData_rdata = rdata; MemData_rvalid = rvalid;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input logic v, input logic mrd, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [2:0] f3, input logic [31:0] rdata,
                         input logic exp_we, input logic chk_data, input logic [4:0] exp_rd,
                         input logic [31:0] exp_data);
    vec_t t;
    t.name = name; t.valid = v; t.rw = 1'b1; t.m2r = mrd; t.mrd = mrd; t.rd = rd;
    t.alu = alu; t.f3 = f3; t.rdata = rdata; t.rvalid = mrd;
    t.exp_we = exp_we; t.chk_data = chk_data; t.exp_rd = exp_rd; t.exp_data = exp_data;
    vecs.push_back(t);
  endtask

  initial begin
    add_vec("add_x5",   1, 0, 5,  32'h1234_5678, 3'b000, 32'h0,          1, 1, 5,  32'h1234_5678);
    add_vec("alu_x0",   1, 0, 0,  32'h0000_DEAD, 3'b000, 32'h0,          0, 1, 0,  32'h0000_DEAD);
    add_vec("bubble",   0, 0, 6,  32'h1111_1111, 3'b000, 32'h0,          0, 0, 0,  32'h0);
    add_vec("lb_a3",    1, 1, 10, 32'h0000_0103, 3'b000, 32'h8081_8283,  1, 1, 10, 32'hFFFF_FF80);
    add_vec("lbu_a0",   1, 1, 11, 32'h0000_0100, 3'b100, 32'h8081_8283,  1, 1, 11, 32'h0000_0083);
    add_vec("lbu_a1",   1, 1, 11, 32'h0000_0101, 3'b100, 32'h8081_8283,  1, 1, 11, 32'h0000_0082);
    add_vec("lh_a2",    1, 1, 12, 32'h0000_0102, 3'b001, 32'h8081_8283,  1, 1, 12, 32'hFFFF_8081);
    add_vec("lh_a1",    1, 1, 12, 32'h0000_0101, 3'b001, 32'h8081_8283,  1, 1, 12, 32'hFFFF_8283);
    add_vec("lhu_a0",   1, 1, 13, 32'h0000_0100, 3'b101, 32'h8081_8283,  1, 1, 13, 32'h0000_8283);
    add_vec("lw",       1, 1, 14, 32'h0000_0100, 3'b010, 32'h8081_8283,  1, 1, 14, 32'h8081_8283);
    add_vec("f3_011",   1, 1, 15, 32'h0000_0101, 3'b011, 32'h8081_8283,  1, 1, 15, 32'h8081_8283);
    add_vec("lb_x0",    1, 1, 0,  32'h0000_0100, 3'b000, 32'h0000_007F,  0, 1, 0,  32'h0000_007F);

`ifdef WB_BYPASS_EN
    rs1Addr_id = 0; rs2Addr_id = 0; rs1Data_rf = 0; rs2Data_rf = 0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    chk("reset_we",    {31'd0, RegWrite_wb}, 32'd0);
    chk("reset_rd",    {27'd0, rdAddr_wb}, 32'd0);
    chk("reset_data",  RegWriteData_wb, 32'd0);
    chk("reset_stall", {31'd0, WBStall}, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].mrd, vecs[i].rd, vecs[i].alu,
            vecs[i].f3, vecs[i].rdata, vecs[i].rvalid);
      tick;
      chk({vecs[i].name, "_we"}, {31'd0, RegWrite_wb}, {31'd0, vecs[i].exp_we});
      chk({vecs[i].name, "_stall"}, {31'd0, WBStall}, 32'd0);
      if (vecs[i].chk_data) begin
        chk({vecs[i].name, "_rd"}, {27'd0, rdAddr_wb}, {27'd0, vecs[i].exp_rd});
        chk({vecs[i].name, "_data"}, RegWriteData_wb, vecs[i].exp_data);
      end
    end

    // Late load: accepted at edge N, rvalid at edge N+3, next instruction held behind it.
    drive(1, 1, 1, 1, 9, 32'h0000_0200, 3'b010, 32'h0, 0);
    tick;
    chk("late_n1_stall", {31'd0, WBStall}, 32'd1);
    chk("late_n1_we", {31'd0, RegWrite_wb}, 32'd0);
    drive(1, 1, 0, 0, 3, 32'h0000_0055, 3'b000, 32'h0, 0);
    tick;
    chk("late_n2_stall", {31'd0, WBStall}, 32'd1);
    chk("late_n2_we", {31'd0, RegWrite_wb}, 32'd0);
    tick;
    chk("late_n3_stall", {31'd0, WBStall}, 32'd1);
    MemData_rdata = 32'hCAFE_F00D; MemData_rvalid = 1'b1;
    tick;
    chk("late_n4_stall", {31'd0, WBStall}, 32'd0);
    chk("late_n4_we", {31'd0, RegWrite_wb}, 32'd1);
    chk("late_n4_rd", {27'd0, rdAddr_wb}, 32'd9);
    chk("late_n4_data", RegWriteData_wb, 32'hCAFE_F00D);
    MemData_rvalid = 1'b0;
    tick;
    chk("late_n5_we", {31'd0, RegWrite_wb}, 32'd1);
    chk("late_n5_rd", {27'd0, rdAddr_wb}, 32'd3);
    chk("late_n5_data", RegWriteData_wb, 32'h0000_0055);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("late_pulse_we", {31'd0, RegWrite_wb}, 32'd0);

    // Reset in WAIT_LOAD, with rvalid on the reset edge and again after it.
    drive(1, 1, 1, 1, 20, 32'h0000_0300, 3'b010, 32'h0, 0);
    tick;
    chk("rst_wait_stall", {31'd0, WBStall}, 32'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h1357_9BDF, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst_edge_we", {31'd0, RegWrite_wb}, 32'd0);
    chk("rst_edge_stall", {31'd0, WBStall}, 32'd0);
    tick;
    chk("rst_after_we", {31'd0, RegWrite_wb}, 32'd0);
    chk("rst_after_stall", {31'd0, WBStall}, 32'd0);
    MemData_rvalid = 1'b0;

`ifdef WB_BYPASS_EN
    drive(1, 1, 0, 0, 7, 32'h0000_00AA, 3'b000, 32'h0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rs1Addr_id = 7; rs1Data_rf = 32'h0; rs2Addr_id = 8; rs2Data_rf = 32'h2222_2222;
    #1;
    chk("byp_rs1_hit", rs1Data_byp, 32'h0000_00AA);
    chk("byp_rs2_miss", rs2Data_byp, 32'h2222_2222);
    rs1Addr_id = 0; rs1Data_rf = 32'h1111_1111;
    #1;
    chk("byp_rs1_x0", rs1Data_byp, 32'h1111_1111);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
